// File: rtl/period_meter_if.sv
// Bundles the measured input, the clear control and the measurement results
// of period_meter; the slave modport is the meter's view.
interface period_meter_if #(
    parameter int CNT_W = 24
) ();
    logic             i_sig_in;
    logic             i_clear;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high_time;
    logic             o_meas_valid;
    logic             o_timeout;
    logic             o_armed;

    modport slave (
        input  i_sig_in,
        input  i_clear,
        output o_period,
        output o_high_time,
        output o_meas_valid,
        output o_timeout,
        output o_armed
    );

    modport master (
        output i_sig_in,
        output i_clear,
        input  o_period,
        input  o_high_time,
        input  o_meas_valid,
        input  o_timeout,
        input  o_armed
    );
endinterface

// File: rtl/period_meter.sv
// Times rising-to-rising and rising-to-falling edges of a slow asynchronous
// square wave in clk cycles; a watchdog drops back to idle on a stalled input.
module period_meter #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 200000
) (
    input  logic          clk,
    input  logic          rst,
    period_meter_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    // [0],[1] form the synchronizer, [2] is the delay flop for edge detection
    logic [2:0]       r_sync;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_hi_cap;
    logic [CNT_W-1:0] w_hi_cap_next;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_next;
    logic [CNT_W-1:0] r_high_time;
    logic [CNT_W-1:0] w_high_time_next;
    logic             r_meas_valid;
    logic             w_meas_valid_next;
    logic             r_timeout;
    logic             w_timeout_next;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rise    = r_sync[1] & ~r_sync[2];
    assign w_fall    = ~r_sync[1] & r_sync[2];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], bus.i_sig_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hi_cap     <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_hi_cap     <= w_hi_cap_next;
            r_period     <= w_period_next;
            r_high_time  <= w_high_time_next;
            r_meas_valid <= w_meas_valid_next;
            r_timeout    <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_hi_cap_next     = r_hi_cap;
        w_period_next     = r_period;
        w_high_time_next  = r_high_time;
        w_meas_valid_next = 1'b0;
        w_timeout_next    = r_timeout;

        if (bus.i_clear) begin
            w_state_next     = ST_IDLE;
            w_cnt_next       = '0;
            w_hi_cap_next    = '0;
            w_period_next    = '0;
            w_high_time_next = '0;
            w_timeout_next   = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_MEASURE;
                        w_cnt_next   = '0;
                    end
                end
                ST_MEASURE: begin
                    // a rise on the watchdog's last cycle still closes a valid period
                    if (w_rise) begin
                        w_period_next     = w_cnt_inc;
                        w_high_time_next  = r_hi_cap;
                        w_meas_valid_next = 1'b1;
                        w_timeout_next    = 1'b0;
                        w_cnt_next        = '0;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        w_state_next   = ST_IDLE;
                        w_timeout_next = 1'b1;
                        w_cnt_next     = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                        if (w_fall) begin
                            w_hi_cap_next = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_period     = r_period;
    assign bus.o_high_time  = r_high_time;
    assign bus.o_meas_valid = r_meas_valid;
    assign bus.o_timeout    = r_timeout;
    assign bus.o_armed      = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed and random square waves for period_meter, checked every cycle
// against a timestamp model of edges, measurements, watchdog and clear.
module tb_period_meter;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
    localparam int MAXC    = 65536;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) u_if ();

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;

    // s_hist[n] / c_hist[n]: sig_in / clear as sampled at posedge n
    bit s_hist [MAXC];
    bit c_hist [MAXC];

    bit m_armed     = 1'b0;
    int m_last_rise = 0;
    int m_period    = 0;
    int m_high      = 0;
    int m_hicap     = 0;
    bit m_timeout   = 1'b0;
    bit m_valid     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, exp, k);
        end
    endtask

    // Effects of an input edge sampled at posedge n show at the negedge after posedge n+2.
    task automatic model_step();
        bit rise_k;
        bit fall_k;
        int age;
        rise_k  = (k >= 3) && s_hist[k-2] && !s_hist[k-3];
        fall_k  = (k >= 3) && !s_hist[k-2] && s_hist[k-3];
        age     = (k - 2) - m_last_rise;
        m_valid = 1'b0;
        if (c_hist[k]) begin
            m_armed   = 1'b0;
            m_period  = 0;
            m_high    = 0;
            m_hicap   = 0;
            m_timeout = 1'b0;
        end else if (m_armed) begin
            if (rise_k) begin
                m_valid     = 1'b1;
                m_period    = age;
                m_high      = m_hicap;
                m_timeout   = 1'b0;
                m_last_rise = k - 2;
            end else if (age == TIMEOUT) begin
                m_armed   = 1'b0;
                m_timeout = 1'b1;
            end else if (fall_k) begin
                m_hicap = age;
            end
        end else if (rise_k) begin
            m_armed     = 1'b1;
            m_last_rise = k - 2;
        end
    endtask

    task automatic tick(input bit v, input bit c);
        @(negedge clk);
        k++;
        if (k >= MAXC - 1) begin
            $display("FAIL cycle_budget: observed %0d required below %0d", k, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        model_step();
        check("meas_valid", 32'(u_if.o_meas_valid), 32'(m_valid));
        check("period",     32'(u_if.o_period),     m_period);
        check("high_time",  32'(u_if.o_high_time),  m_high);
        check("timeout",    32'(u_if.o_timeout),    32'(m_timeout));
        check("armed",      32'(u_if.o_armed),      32'(m_armed));
        if (u_if.o_meas_valid === 1'b1)
            $display("meas cycle %0d period %0d high_time %0d", k, u_if.o_period, u_if.o_high_time);
        u_if.i_sig_in = v;
        u_if.i_clear  = c;
        s_hist[k+1]   = v;
        c_hist[k+1]   = c;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < h; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < l; i++) tick(1'b0, 1'b0);
        end
    endtask

    initial begin
        u_if.i_sig_in = 1'b0;
        u_if.i_clear  = 1'b0;
        #1 rst = 1'b0;
        repeat (4) tick(1'b0, 1'b0);
        rst = 1'b1;

        wave(50, 50, 4);
        check("sq_period", 32'(u_if.o_period), 100);
        check("sq_high",   32'(u_if.o_high_time), 50);

        wave(30, 70, 3);
        check("d30_high", 32'(u_if.o_high_time), 30);
        wave(70, 30, 3);
        check("d70_high", 32'(u_if.o_high_time), 70);

        wave(500, 500, 2);
        check("p1000_period",  32'(u_if.o_period), 1000);
        check("p1000_timeout", 32'(u_if.o_timeout), 0);

        wave(400, 601, 1);
        repeat (5) tick(1'b0, 1'b0);
        check("p1001_timeout", 32'(u_if.o_timeout), 1);
        check("p1001_armed",   32'(u_if.o_armed), 0);
        check("p1001_hold",    32'(u_if.o_period), 1000);

        wave(50, 50, 3);
        repeat (1100) tick(1'b0, 1'b0);
        check("stall_timeout", 32'(u_if.o_timeout), 1);
        check("stall_hold",    32'(u_if.o_period), 100);

        wave(100, 100, 3);
        check("resume_period",  32'(u_if.o_period), 200);
        check("resume_timeout", 32'(u_if.o_timeout), 0);

        wave(2, 2, 8);
        check("min_period", 32'(u_if.o_period), 4);
        check("min_high",   32'(u_if.o_high_time), 2);

        for (int r = 0; r < 12; r++)
            wave(int'($urandom_range(2, 600)), int'($urandom_range(2, 600)), 1);

        wave(50, 50, 2);
        repeat (20) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("clear_period", 32'(u_if.o_period), 0);
        check("clear_armed",  32'(u_if.o_armed), 0);
        repeat (28) tick(1'b1, 1'b0);
        repeat (50) tick(1'b0, 1'b0);
        wave(50, 50, 3);
        check("after_clear_period", 32'(u_if.o_period), 100);

        repeat (30) tick(1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_period",     32'(u_if.o_period), 0);
        check("rst_high",       32'(u_if.o_high_time), 0);
        check("rst_meas_valid", 32'(u_if.o_meas_valid), 0);
        check("rst_timeout",    32'(u_if.o_timeout), 0);
        check("rst_armed",      32'(u_if.o_armed), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
